// File: rtl/ray_setup_recip.sv
// ray_setup_recip: converts a ray direction into its Q18.18 reciprocal for the
// ray/box slab test. Three radix-2 restoring dividers run in lockstep. Each one
// computes 2^(18+FRAC_BITS) / |d|. The sign is applied afterwards, and zero
// divisors are flagged and forced to 0. The result is held until the traversal
// stage accepts it.
module ray_setup_recip #(
  parameter int FRAC_BITS = 16,
  parameter int ORIG_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0][ORIG_W-1:0]   ray_orig,
  input  logic [2:0][27:0]         ray_dir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0][ORIG_W-1:0]   out_ray_orig,
  output logic [2:0][35:0]         inv_ray_dir,
  output logic [2:0]               div_by_zero
);

  // Dividend 2^(18+FRAC_BITS) is DW bits wide, and so is the quotient.
  // The step counter runs from DW-1 down to 0, which gives DW restoring steps.
  localparam int DW    = 19 + FRAC_BITS;
  localparam int CNT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]        r_cnt;
  logic [DW-1:0]           r_dvd;      // dividend, shifted out MSB first
  logic [2:0]              r_sign;
  logic [2:0][27:0]        r_mag;
  logic [2:0][27:0]        r_rem;
  logic [2:0][DW-1:0]      r_q;
  logic [2:0][ORIG_W-1:0]  r_orig;

  logic [2:0][ORIG_W-1:0]  r_out_orig;
  logic [2:0][35:0]        r_inv;
  logic [2:0]              r_dbz;
  logic                    r_out_valid;

  logic [2:0][27:0]        w_mag;      // |ray_dir| at the input, 28-bit unsigned
  logic [2:0][28:0]        w_trial;    // partial remainder with the next dividend bit
  logic [2:0]              w_ge;       // trial >= divisor, i.e. the quotient bit
  logic [2:0][27:0]        w_rem_nxt;
  logic [2:0][35:0]        w_inv_nxt;

  // Magnitude of each incoming direction component.
  // -2^27 maps to 2^27, which still fits in 28 unsigned bits.
  always_comb begin
    // NOTE: every output of a combinational block is assigned before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    w_mag = '0;
    for (int i = 0; i < 3; i++) begin
      w_mag[i] = ray_dir[i][27] ? (~ray_dir[i] + 28'd1) : ray_dir[i];
    end
  end

  // One restoring step per axis.
  // The remainder stays below |d| <= 2^27, so the shifted trial value
  // needs one extra bit to compare safely.
  always_comb begin
    w_trial   = '0;
    w_ge      = '0;
    w_rem_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      w_trial[i]   = {r_rem[i], r_dvd[DW-1]};
      w_ge[i]      = (w_trial[i] >= {1'b0, r_mag[i]});
      w_rem_nxt[i] = w_ge[i] ? 28'(w_trial[i] - {1'b0, r_mag[i]}) : w_trial[i][27:0];
    end
  end

  // Signed Q18.18 result per axis.
  // A zero divisor produces an all-ones quotient, which is replaced by 0 here.
  always_comb begin
    w_inv_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      if (r_mag[i] != '0) begin
        w_inv_nxt[i] = r_sign[i] ? -36'(r_q[i]) : 36'(r_q[i]);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: one handshake in, DW divide steps, one fix-up cycle,
  // then hold until the result is taken.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)       w_state_nxt = S_DIV;
      S_DIV:   if (r_cnt == '0)    w_state_nxt = S_FIX;
      S_FIX:                       w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready)      w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready = (r_state == S_IDLE);

  // Operand capture, lockstep divide, sign fix-up and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_sign      <= '0;
      r_mag       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_orig      <= '0;
      r_out_orig  <= '0;
      r_inv       <= '0;
      r_dbz       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_orig <= ray_orig;
            r_dvd  <= {1'b1, {(DW-1){1'b0}}};
            r_cnt  <= CNT_INIT;
            r_rem  <= '0;
            r_q    <= '0;
            for (int i = 0; i < 3; i++) begin
              r_sign[i] <= ray_dir[i][27];
              r_mag[i]  <= w_mag[i];
            end
          end
        end
        S_DIV: begin
          r_dvd <= r_dvd << 1;
          r_rem <= w_rem_nxt;
          for (int i = 0; i < 3; i++) begin
            r_q[i] <= {r_q[i][DW-2:0], w_ge[i]};
          end
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          r_inv       <= w_inv_nxt;
          r_out_orig  <= r_orig;
          r_out_valid <= 1'b1;
          for (int i = 0; i < 3; i++) begin
            r_dbz[i] <= (r_mag[i] == '0);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign out_ray_orig = r_out_orig;
  assign inv_ray_dir  = r_inv;
  assign div_by_zero  = r_dbz;

endmodule

// File: tb/tb_ray_setup_recip.sv
// tb_ray_setup_recip: directed bench for ray_setup_recip.
// The scoreboard predicts each accepted ray with plain integer division,
// trunc(2^34/|d|) with the sign applied. It also predicts when out_valid and
// in_ready must be high, based on the acceptance edge.
module tb_ray_setup_recip;

  localparam int FRAC_BITS = 16;
  localparam int LAT       = 20 + FRAC_BITS;   // acceptance edge to out_valid edge
  localparam int II        = LAT + 2;          // acceptance to acceptance

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [2:0][31:0]    ray_orig;
  logic [2:0][27:0]    ray_dir;
  logic                out_valid;
  logic                out_ready;
  logic [2:0][31:0]    out_ray_orig;
  logic [2:0][35:0]    inv_ray_dir;
  logic [2:0]          div_by_zero;

  ray_setup_recip #(.FRAC_BITS(FRAC_BITS), .ORIG_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ray_orig     (ray_orig),
    .ray_dir      (ray_dir),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ray_orig (out_ray_orig),
    .inv_ray_dir  (inv_ray_dir),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  always @(posedge clk) cycle++;

  typedef struct {
    logic [2:0][31:0] orig;
    logic [2:0][35:0] inv;
    logic [2:0]       dbz;
    int               acc;
  } exp_t;

  exp_t q_exp[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference reciprocal: 2^(18+FRAC_BITS) / |d|, truncated, then signed.
  function automatic logic [35:0] model_recip(input logic [27:0] d);
    longint sd;
    longint mag;
    longint q;
    sd  = {{36{d[27]}}, d};
    mag = (sd < 0) ? -sd : sd;
    if (mag == 0) return '0;
    q = (longint'(1) << (18 + FRAC_BITS)) / mag;
    if (sd < 0) q = -q;
    return q[35:0];
  endfunction

  // Compare process: checks handshake timing every cycle and checks the data
  // whenever out_valid is high. It also records each acceptance.
  always @(negedge clk) begin : cmp
    exp_t e;
    bit   exp_valid;
    if (!rst_n) begin
      q_exp.delete();
    end else begin
      check("in_ready_vs_model", in_ready, q_exp.size() == 0);
      exp_valid = 1'b0;
      if (q_exp.size() != 0) exp_valid = (cycle >= q_exp[0].acc + LAT);
      check("out_valid_vs_model", out_valid, exp_valid);
      if (out_valid && q_exp.size() != 0) begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("inv_ray_dir[%0d]", i), inv_ray_dir[i], q_exp[0].inv[i]);
          check($sformatf("out_ray_orig[%0d]", i), out_ray_orig[i], q_exp[0].orig[i]);
        end
        check("div_by_zero", div_by_zero, q_exp[0].dbz);
        if (out_ready) void'(q_exp.pop_front());
      end
      if (in_valid && in_ready) begin
        e.orig = ray_orig;
        for (int i = 0; i < 3; i++) begin
          e.inv[i] = model_recip(ray_dir[i]);
          e.dbz[i] = (ray_dir[i] == '0);
        end
        e.acc = cycle + 1;
        q_exp.push_back(e);
      end
    end
  end

  // Present a ray and hold in_valid until it is accepted.
  // acc returns the acceptance edge.
  task automatic send(input logic [2:0][31:0] o, input logic [2:0][27:0] d, output int acc);
    @(posedge clk); #1;
    ray_orig = o;
    ray_dir  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    acc      = cycle;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid. rise returns the edge at which it was first seen high.
  task automatic wait_valid(output int rise);
    rise = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (out_valid) begin
        rise = cycle;
        break;
      end
    end
    if (rise < 0) check("out_valid_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int rise;
    int hs;
    int acc_log[4];
    logic [31:0] r;
    logic [2:0][27:0] dir_a;
    logic [2:0][31:0] orig_a;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ray_orig  = '0;
    ray_dir   = '0;

    // Hand-computed values that pin the reference model.
    check("pin_model_1p0",  model_recip(28'h0010000), 36'h0_0004_0000);
    check("pin_model_m0p5", model_recip(28'hFFF8000), 36'hF_FFF8_0000);
    check("pin_model_3p0",  model_recip(28'h0030000), 36'h0_0001_5555);
    check("pin_model_min",  model_recip(28'h8000000), 36'hF_FFFF_FF80);
    check("pin_model_zero", model_recip(28'h0000000), 36'h0);

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_inv", inv_ray_dir, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_orig", out_ray_orig, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ray (1.0, -0.5, 3.0).
    send({32'h33, 32'h22, 32'h11}, {28'h0030000, 28'hFFF8000, 28'h0010000}, acc);
    wait_valid(rise);
    check("t1_latency", rise - acc, LAT);
    check("t1_inv_x", inv_ray_dir[0], 36'h0_0004_0000);
    check("t1_inv_y", inv_ray_dir[1], 36'hF_FFF8_0000);
    check("t1_inv_z", inv_ray_dir[2], 36'h0_0001_5555);
    check("t1_dbz", div_by_zero, 3'b000);
    check("t1_orig_x", out_ray_orig[0], 32'h11);
    check("t1_orig_z", out_ray_orig[2], 32'h33);

    // Zero and extreme divisors.
    send({32'hC, 32'hB, 32'hA}, {28'h8000000, 28'h0000001, 28'h0000000}, acc);
    wait_valid(rise);
    check("t2_latency", rise - acc, LAT);
    check("t2_dbz", div_by_zero, 3'b001);
    check("t2_inv_x", inv_ray_dir[0], 36'h0);
    check("t2_inv_y", inv_ray_dir[1], 36'h4_0000_0000);
    check("t2_inv_z", inv_ray_dir[2], 36'hF_FFFF_FF80);

    // Back-pressure: hold for 10 cycles while the input side keeps changing.
    @(posedge clk); #1;
    out_ready = 1'b0;
    dir_a  = {28'h0000100, 28'hFFF0000, 28'h0050000};
    orig_a = {32'hA3, 32'hA2, 32'hA1};
    send(orig_a, dir_a, acc);
    wait_valid(rise);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      ray_dir  = {28'(k * 3 + 1), 28'(k * 5 + 7), 28'h0040000 + 28'(k)};
      ray_orig = {32'(k), 32'(k + 100), 32'(k + 200)};
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_inv_x", inv_ray_dir[0], model_recip(dir_a[0]));
      check("bp_inv_y", inv_ray_dir[1], model_recip(dir_a[1]));
      check("bp_inv_z", inv_ray_dir[2], model_recip(dir_a[2]));
      check("bp_orig_y", out_ray_orig[1], orig_a[1]);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    hs = cycle + 1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_valid_dropped", out_valid, 0);
    check("bp_ready_after_hs", in_ready, 1);
    @(posedge clk); #1;
    acc      = cycle;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_pending_accepted", in_ready, 0);
    check("bp_accept_edge", acc - hs, 1);
    out_ready = 1'b1;
    wait_valid(rise);
    check("bp_latency", rise - acc, LAT);

    // Back-to-back stream with out_ready held high.
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        r = $urandom();
        ray_dir[i] = r[27:0];
        ray_orig[i] = $urandom();
      end
      for (int w = 0; w < 100; w++) begin
        @(negedge clk);
        if (in_ready) break;
      end
      if (!in_ready) check("stream_accept_timeout", 0, 1);
      @(posedge clk); #1;
      acc_log[k] = cycle;
    end
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      check($sformatf("stream_ii_%0d", k), acc_log[k] - acc_log[k-1], II);
    end
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (q_exp.size() == 0) break;
    end
    check("stream_drained", q_exp.size(), 0);

    // Reset mid-DIV, at step 20.
    send({32'h7, 32'h8, 32'h9}, {28'hFF00000, 28'h0012345, 28'h0010000}, acc);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_inv", inv_ray_dir, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    check("mid_rst_orig", out_ray_orig, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send({32'h3, 32'h2, 32'h1}, {28'h0020000, 28'h0020000, 28'h0020000}, acc);
    wait_valid(rise);
    check("post_rst_latency", rise - acc, LAT);
    check("post_rst_inv_x", inv_ray_dir[0], 36'h0_0002_0000);
    check("post_rst_inv_y", inv_ray_dir[1], 36'h0_0002_0000);
    check("post_rst_inv_z", inv_ray_dir[2], 36'h0_0002_0000);
    check("post_rst_dbz", div_by_zero, 3'b000);
    check("post_rst_orig_x", out_ray_orig[0], 32'h1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
